dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined RV32 core. It answers the core's load/store requests, which carry an address, write data and funct3 size/sign encoding, over a valid/ready request channel and a valid/ready response channel. It owns a word-organised single-port RAM with a configurable number of wait states. It performs byte-lane steering, store byte enables, load sign/zero extension and misalignment/range checking.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `WAIT_CYCLES`, 1: extra cycles between accept and RAM access; legal range 0..15.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_funct3`  in  3  RV32 load/store funct3.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  core accepts response.
- `rsp_rdata`  out  32  load result, extended; 0 for stores and errors.
- `rsp_err`  out  1  misaligned, illegal funct3 or out-of-range access.

## Operation
- FSM states: IDLE, WAIT, RESP. `req_ready` = (state == IDLE).
- **IDLE:** if `req_valid` is high, capture the request and check it.
  - Error: go to RESP with `rsp_err`=1 and `rsp_rdata`=0. No RAM access.
  - No error, `WAIT_CYCLES`=0: go to RESP.
  - No error, otherwise: go to WAIT with the counter loaded to `WAIT_CYCLES`-1.
- **WAIT:** decrement the counter. When it reaches 0, go to RESP.
- The RAM access happens only on the transition into RESP for a non-error request.
  - A store writes the enabled byte lanes.
  - A load registers the extended result into `rsp_rdata`.
- **RESP:** hold `rsp_valid`=1 and stable data until `rsp_ready` is high, then return to IDLE.
  - No request is accepted in that same cycle. At most one request is outstanding.
- Legal loads: 000 LB (sign), 001 LH (sign), 010 LW, 100 LBU (zero), 101 LHU (zero). Other load funct3 values are errors.
- Legal stores: 000 SB, 001 SH, 010 SW. Other store funct3 values are errors.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00. A violation is an error.
- Range: word index addr[31:2] >= `DEPTH_WORDS` is an error.
- Lane steering:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Store: replicate data across lanes; byte enables are one-hot (byte), pair (half) or all (word).
  - Load: shift the selected lane to bit 0, then extend to 32 bits.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values:
  - state IDLE, so `req_ready`=1.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter 0.
- Accept edge = cycle 0. `rsp_valid` rises at:
  - cycle 1 + `WAIT_CYCLES` for a legal access;
  - cycle 1 for an error.
- `rsp_valid` stays high until the edge where `rsp_ready` is sampled high. IDLE, with `req_ready`=1, follows on the next cycle.
- Steady-state throughput is one request per (`WAIT_CYCLES` + 2) cycles with `rsp_ready` held high.
- A store is committed at the edge entering RESP. A load at the same address accepted afterward returns the new data.
- Reset asserted mid-operation:
  - Immediate return to IDLE; `rsp_valid` and `rsp_err` clear asynchronously.
  - A store still in WAIT is dropped; the RAM is not written.
- In RESP, `rsp_rdata` and `rsp_err` do not change while `rsp_valid`=1 and `rsp_ready`=0.
- `req_*` inputs are ignored outside IDLE.

## Structure
- Shared package `dmem_pkg`:
  - funct3 constants F3_B/H/W/BU/HU;
  - FSM state enum;
  - `WAIT_CYCLES` counter width constant (4 bits).
- Sub-module `dmem_lane_align`, combinational:
  - store path: byte enables and replicated write word;
  - load path: lane select and sign/zero extension;
  - error flag from funct3/alignment.
  - Unit-testable on its own.
- Top level: FSM, counter, request capture, RAM array and response registers.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 -> rdata 0xDEADBEEF, err 0; with `WAIT_CYCLES`=1, `rsp_valid` at cycle 2 after accept.
- SB 0x80 to 0x13, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
- LH 0x11 -> err 1, rdata 0, `rsp_valid` at cycle 1; LW with funct3 011 -> err 1; SW to word index `DEPTH_WORDS` -> err 1, RAM unchanged.
- Backpressure: `rsp_ready` low for 5 cycles -> `rsp_valid`, `rsp_rdata` and `rsp_err` stable, `req_ready` 0 throughout; `req_ready` 1 the cycle after the handshake.
- Reset pulse while SW 0x12345678 to 0x20 is in WAIT (`WAIT_CYCLES`=3) -> outputs return to reset values; the later LW 0x20 returns the prior contents.
- `WAIT_CYCLES`=0: SH 0xBEEF to 0x22, then LHU 0x22 -> 0x0000BEEF at cycle 1; LH 0x22 -> 0xFFFFBEEF.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state type, wait counter width and a funct3 legality helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width of the wait-state counter; holds WAIT_CYCLES-1 for 0..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Stores accept B/H/W only; loads additionally accept BU/HU.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the core (master) and the data-memory
// responder (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for a 32-bit word-organised RAM:
// store byte enables / replicated write word, load lane select with
// sign or zero extension, and the funct3/alignment error flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic [31:0] shifted_s;
    logic        misalign_s;

    // Store path: replicate right-aligned data across lanes, enable the addressed lanes.
    always_comb begin
        be_o    = 4'b0000;
        wword_o = 32'd0;
        case (funct3_i)
            F3_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
            end
            F3_W: begin
                be_o    = 4'b1111;
                wword_o = wdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wword_o = 32'd0;
            end
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted_s = rword_i >> {addr_lo_i, 3'b000};
        case (funct3_i)
            F3_B:    rdata_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    rdata_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    rdata_o = rword_i;
            F3_BU:   rdata_o = {24'd0, shifted_s[7:0]};
            F3_HU:   rdata_o = {16'd0, shifted_s[15:0]};
            default: rdata_o = 32'd0;
        endcase
    end

    // Error flag: unsupported funct3 or an access that is not naturally aligned.
    always_comb begin
        if (funct3_i[1:0] == 2'b01) begin
            misalign_s = addr_lo_i[0];
        end else if (funct3_i[1:0] == 2'b10) begin
            misalign_s = (addr_lo_i != 2'b00);
        end else begin
            misalign_s = 1'b0;
        end
        err_o = !f3_legal(we_i, funct3_i) || misalign_s;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits
// WAIT_CYCLES, performs the RAM access on entry to RESP and holds the
// response until the core takes it. DEPTH_WORDS must be a power of two >= 2.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Captured request, used while waiting.
    logic               we_q;
    logic [2:0]         funct3_q;
    logic [1:0]         lo_q;
    logic [AW-1:0]      idx_q;
    logic [31:0]        wdata_q;

    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [31:0]        ram_q [DEPTH_WORDS];

    // Access currently being serviced: live inputs in IDLE, captured copy otherwise.
    logic               sel_we_s;
    logic [2:0]         sel_funct3_s;
    logic [1:0]         sel_lo_s;
    logic [AW-1:0]      sel_idx_s;
    logic [31:0]        sel_wdata_s;

    logic [3:0]         be_s;
    logic [31:0]        wword_s;
    logic [31:0]        align_rdata_s;
    logic               align_err_s;
    logic               range_err_s;
    logic               req_err_s;
    logic               resp_err_s;
    logic               enter_resp_s;
    logic               ram_wr_s;

    // Select the live request in IDLE (zero-wait access happens at accept), else the captured one.
    always_comb begin
        if (state_q == ST_IDLE) begin
            sel_we_s     = bus.req_we;
            sel_funct3_s = bus.req_funct3;
            sel_lo_s     = bus.req_addr[1:0];
            sel_idx_s    = bus.req_addr[AW+1:2];
            sel_wdata_s  = bus.req_wdata;
        end else begin
            sel_we_s     = we_q;
            sel_funct3_s = funct3_q;
            sel_lo_s     = lo_q;
            sel_idx_s    = idx_q;
            sel_wdata_s  = wdata_q;
        end
    end

    dmem_lane_align u_align (
        .we_i      (sel_we_s),
        .addr_lo_i (sel_lo_s),
        .funct3_i  (sel_funct3_s),
        .wdata_i   (sel_wdata_s),
        .rword_i   (ram_q[sel_idx_s]),
        .be_o      (be_s),
        .wword_o   (wword_s),
        .rdata_o   (align_rdata_s),
        .err_o     (align_err_s)
    );

    // Request error: lane/funct3 problem or word index beyond the RAM.
    always_comb begin
        range_err_s = ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));
        req_err_s   = align_err_s || range_err_s;
        // Only requests straight out of IDLE can be in error; WAIT holds legal ones only.
        if (state_q == ST_IDLE) begin
            resp_err_s = req_err_s;
        end else begin
            resp_err_s = 1'b0;
        end
    end

    // State, counter and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Capture the request at the accept edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            lo_q     <= 2'd0;
            idx_q    <= {AW{1'b0}};
            wdata_q  <= 32'd0;
        end else if ((state_q == ST_IDLE) && bus.req_valid) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            lo_q     <= bus.req_addr[1:0];
            idx_q    <= bus.req_addr[AW+1:2];
            wdata_q  <= bus.req_wdata;
        end
    end

    // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE; errors skip WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (req_err_s || (WAIT_CYCLES == 0)) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic: load/commit on entry to RESP, hold while stalled, clear on handshake.
    always_comb begin
        enter_resp_s = (state_d == ST_RESP) && (state_q != ST_RESP);
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        ram_wr_s     = 1'b0;
        if (enter_resp_s) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = resp_err_s;
            rsp_rdata_d = (resp_err_s || sel_we_s) ? 32'd0 : align_rdata_s;
            ram_wr_s    = !resp_err_s && sel_we_s;
        end else if ((state_q == ST_RESP) && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // RAM write port: byte-enabled store; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_wr_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    ram_q[sel_idx_s][b*8 +: 8] <= wword_s[b*8 +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 0, 1, 3) driven by
// directed steps and random traffic, checked against a byte-array memory model.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n      [3];
    logic        req_valid  [3];
    logic        req_we     [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [2:0]  req_funct3 [3];
    logic        rsp_ready  [3];
    logic        req_ready  [3];
    logic        rsp_valid  [3];
    logic [31:0] rsp_rdata  [3];
    logic        rsp_err    [3];

    int n_chk;
    int n_fail;

    // Reference memory: one byte array per instance covering addresses 0..255.
    logic [7:0] mem_m [3][256];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WC = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        dmem_responder_if bus_if ();
        assign bus_if.req_valid  = req_valid[g];
        assign bus_if.req_we     = req_we[g];
        assign bus_if.req_addr   = req_addr[g];
        assign bus_if.req_wdata  = req_wdata[g];
        assign bus_if.req_funct3 = req_funct3[g];
        assign bus_if.rsp_ready  = rsp_ready[g];
        assign req_ready[g]      = bus_if.req_ready;
        assign rsp_valid[g]      = bus_if.rsp_valid;
        assign rsp_rdata[g]      = bus_if.rsp_rdata;
        assign rsp_err[g]        = bus_if.rsp_err;
        dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WC)) u_dut (
            .clk (clk),
            .rst (rst_n[g]),
            .bus (bus_if)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int wc_of(input int s);
        case (s)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_err(input bit we, input logic [31:0] a, input logic [2:0] f3);
        bit legal;
        int n;
        n = size_of(f3);
        if (we) legal = f3 inside {3'd0, 3'd1, 3'd2};
        else    legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        return !legal || ((int'(a[1:0]) % n) != 0) || ((a >> 2) >= 32'd1024);
    endfunction

    function automatic logic [31:0] model_load(input int sel, input logic [31:0] a, input logic [2:0] f3);
        int n;
        longint v;
        n = size_of(f3);
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(mem_m[sel][int'(a[7:0]) + i]) << (8 * i);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input int sel, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        int n;
        n = size_of(f3);
        for (int i = 0; i < n; i++) mem_m[sel][int'(a[7:0]) + i] = d[8*i +: 8];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction with latency, stability and handshake checks.
    task automatic do_txn(input int sel, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input int hold, output logic [31:0] rd_o);
        bit          e;
        int          lat_exp;
        int          k;
        logic [31:0] rd_exp;
        string       t;
        e       = model_err(we, addr, f3);
        lat_exp = e ? 1 : 1 + wc_of(sel);
        rd_exp  = (e || we) ? 32'd0 : model_load(sel, addr, f3);
        if (!e && we) model_store(sel, addr, wdata, f3);
        t = $sformatf("s%0d %s a=%h f3=%0d", sel, we ? "st" : "ld", addr, f3);
        @(negedge clk);
        chk({t, " req_ready_idle"}, {31'd0, req_ready[sel]}, 32'd1);
        req_valid[sel]  = 1'b1;
        req_we[sel]     = we;
        req_addr[sel]   = addr;
        req_wdata[sel]  = wdata;
        req_funct3[sel] = f3;
        @(posedge clk);
        #1;
        // Junk store offered while busy must be ignored.
        req_we[sel]     = 1'b1;
        req_addr[sel]   = 32'($urandom_range(0, 63)) << 2;
        req_wdata[sel]  = $urandom;
        req_funct3[sel] = 3'b010;
        chk({t, " req_ready_busy"}, {31'd0, req_ready[sel]}, 32'd0);
        k = 1;
        while (rsp_valid[sel] !== 1'b1 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({t, " latency"}, 32'(k), 32'(lat_exp));
        chk({t, " rsp_valid"}, {31'd0, rsp_valid[sel]}, 32'd1);
        chk({t, " rdata"}, rsp_rdata[sel], rd_exp);
        chk({t, " err"}, {31'd0, rsp_err[sel]}, {31'd0, e});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({t, " hold_valid"}, {31'd0, rsp_valid[sel]}, 32'd1);
            chk({t, " hold_rdata"}, rsp_rdata[sel], rd_exp);
            chk({t, " hold_err"}, {31'd0, rsp_err[sel]}, {31'd0, e});
            chk({t, " hold_req_ready"}, {31'd0, req_ready[sel]}, 32'd0);
        end
        rd_o = rsp_rdata[sel];
        rsp_ready[sel] = 1'b1;
        req_valid[sel] = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready[sel] = 1'b0;
        chk({t, " valid_after_hs"}, {31'd0, rsp_valid[sel]}, 32'd0);
        chk({t, " ready_after_hs"}, {31'd0, req_ready[sel]}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [2:0]  ld_f3 [5];
        logic [2:0]  st_f3 [3];
        logic [2:0]  f3;
        logic [31:0] a;
        int          sel;
        int          kind;
        bit          we;
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        st_f3 = '{3'd0, 3'd1, 3'd2};
        n_chk  = 0;
        n_fail = 0;
        for (int s = 0; s < 3; s++) begin
            rst_n[s] = 1'b0; req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = 32'd0;
            req_wdata[s] = 32'd0; req_funct3[s] = 3'd0; rsp_ready[s] = 1'b0;
        end
        #12;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("s%0d reset req_ready", s), {31'd0, req_ready[s]}, 32'd1);
            chk($sformatf("s%0d reset rsp_valid", s), {31'd0, rsp_valid[s]}, 32'd0);
            chk($sformatf("s%0d reset rdata", s), rsp_rdata[s], 32'd0);
            chk($sformatf("s%0d reset err", s), {31'd0, rsp_err[s]}, 32'd0);
        end
        @(negedge clk);
        for (int s = 0; s < 3; s++) rst_n[s] = 1'b1;

        // Give every model byte a defined value.
        for (int s = 0; s < 3; s++)
            for (int w = 0; w < 64; w++) do_txn(s, 1'b1, 32'(w * 4), $urandom, 3'b010, 0, rd);

        // WAIT_CYCLES=1 directed steps.
        do_txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, rd);
        do_txn(1, 1'b0, 32'h10, 32'd0, 3'b010, 0, rd);
        chk("lw_10_deadbeef", rd, 32'hDEADBEEF);
        do_txn(1, 1'b1, 32'h13, 32'h00000080, 3'b000, 0, rd);
        do_txn(1, 1'b0, 32'h13, 32'd0, 3'b000, 0, rd);
        chk("lb_13", rd, 32'hFFFFFF80);
        do_txn(1, 1'b0, 32'h13, 32'd0, 3'b100, 0, rd);
        chk("lbu_13", rd, 32'h00000080);
        do_txn(1, 1'b0, 32'h10, 32'd0, 3'b010, 5, rd);
        chk("lw_10_merged", rd, 32'h80ADBEEF);
        do_txn(1, 1'b0, 32'h11, 32'd0, 3'b001, 0, rd);
        do_txn(1, 1'b0, 32'h10, 32'd0, 3'b011, 0, rd);
        do_txn(1, 1'b1, 32'h1000, 32'hCAFEF00D, 3'b010, 0, rd);
        do_txn(1, 1'b0, 32'h0, 32'd0, 3'b010, 0, rd);

        // WAIT_CYCLES=3: reset while a store is waiting.
        @(negedge clk);
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h20;
        req_wdata[2] = 32'h12345678; req_funct3[2] = 3'b010;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[2] = 1'b0;
        #1;
        chk("rst_mid req_ready", {31'd0, req_ready[2]}, 32'd1);
        chk("rst_mid rsp_valid", {31'd0, rsp_valid[2]}, 32'd0);
        chk("rst_mid rdata", rsp_rdata[2], 32'd0);
        chk("rst_mid err", {31'd0, rsp_err[2]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n[2] = 1'b1;
        do_txn(2, 1'b0, 32'h20, 32'd0, 3'b010, 0, rd);

        // WAIT_CYCLES=0 directed steps.
        do_txn(0, 1'b1, 32'h22, 32'h0000BEEF, 3'b001, 0, rd);
        do_txn(0, 1'b0, 32'h22, 32'd0, 3'b101, 0, rd);
        chk("lhu_22", rd, 32'h0000BEEF);
        do_txn(0, 1'b0, 32'h22, 32'd0, 3'b001, 2, rd);
        chk("lh_22", rd, 32'hFFFFBEEF);

        // Random traffic over all instances.
        for (int it = 0; it < 150; it++) begin
            sel  = $urandom_range(0, 2);
            kind = $urandom_range(0, 9);
            we   = 1'($urandom_range(0, 1));
            if (kind < 7) begin
                f3 = we ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
                a  = 32'($urandom_range(0, 255)) & ~32'(size_of(f3) - 1);
            end else if (kind == 7) begin
                f3 = we ? st_f3[$urandom_range(1, 2)] : ld_f3[$urandom_range(1, 4)];
                if (f3 == 3'd4) f3 = 3'd5;
                a  = (32'($urandom_range(0, 255)) & ~32'd3) | (($urandom_range(0, 1) == 0) ? 32'd1 : 32'd3);
            end else if (kind == 8) begin
                f3 = we ? 3'($urandom_range(3, 7)) : (($urandom_range(0, 2) == 0) ? 3'd3 : 3'($urandom_range(6, 7)));
                a  = 32'($urandom_range(0, 63)) << 2;
            end else begin
                f3 = 3'b010;
                a  = 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
            end
            do_txn(sel, we, a, $urandom, f3, $urandom_range(0, 3), rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
